// File: rtl/sd_emmc_dat_tx_ddr.sv
// DDR DAT-line write framer: preamble, start bit, payload, per-line/per-edge CRC16, end bit.
// Output words carry rising-edge bits in the low half and falling-edge bits in the high half.
module sd_emmc_dat_tx_ddr #(
    parameter int DATA_WIDTH = 4,
    parameter int BLK_BYTES  = 512
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [15:0]             blk_num,
    input  logic                    abort,
    input  logic [2*DATA_WIDTH-1:0] s_data,
    input  logic                    s_valid,
    output logic                    s_ready,
    input  logic                    blk_ack,
    output logic [2*DATA_WIDTH-1:0] ddr_d,
    output logic                    ddr_oe,
    output logic                    ddr_clk_en,
    output logic                    busy,
    output logic                    blk_done,
    output logic                    done
);

    localparam int W  = DATA_WIDTH;
    localparam int NB = BLK_BYTES * 8 / (2 * W);
    localparam int BW = $clog2(NB + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_PRE, S_START, S_DATA, S_CRC, S_END, S_WAIT
    } state_t;

    state_t              state_q, state_d;
    logic [15:0]         cnt_q, cnt_d;
    logic [BW-1:0]       beat_q, beat_d;
    logic [3:0]          crc_i_q, crc_i_d;
    logic                wait_entry_q, wait_entry_d;
    logic [W-1:0][15:0]  crc_rise_q, crc_rise_d;
    logic [W-1:0][15:0]  crc_fall_q, crc_fall_d;
    logic [2*W-1:0]      ddr_d_q, ddr_d_d;
    logic                ddr_oe_q, ddr_oe_d;
    logic                clk_en_q, clk_en_d;
    logic                busy_q, busy_d;
    logic                blk_done_q, blk_done_d;
    logic                done_q, done_d;
    logic [15:0]         rem_blks;

    function automatic logic [15:0] crc16_step(input logic [15:0] c, input logic b);
        logic fb;
        fb = c[15] ^ b;
        return {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
    endfunction

    // A beat transfers on any clock where s_valid and s_ready are both high;
    // s_ready depends only on state, never on s_valid.
    assign s_ready  = (state_q == S_DATA);
    // The decrement lands on the WAIT entry cycle, so an ack there must see it already applied.
    assign rem_blks = wait_entry_q ? cnt_q - 16'd1 : cnt_q;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        beat_d       = beat_q;
        crc_i_d      = crc_i_q;
        wait_entry_d = 1'b0;
        crc_rise_d   = crc_rise_q;
        crc_fall_d   = crc_fall_q;
        ddr_d_d      = ddr_d_q;
        ddr_oe_d     = ddr_oe_q;
        clk_en_d     = 1'b1;
        busy_d       = busy_q;
        blk_done_d   = 1'b0;
        done_d       = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start && blk_num != 16'd0) begin
                    state_d = S_PRE;
                    busy_d  = 1'b1;
                    cnt_d   = blk_num;
                end
            end
            S_PRE: begin
                ddr_oe_d   = 1'b1;
                ddr_d_d    = '1;
                crc_rise_d = '0;
                crc_fall_d = '0;
                beat_d     = '0;
                state_d    = S_START;
            end
            S_START: begin
                ddr_d_d = '0;
                state_d = S_DATA;
            end
            S_DATA: begin
                if (s_valid) begin
                    ddr_d_d = {s_data[W-1:0], s_data[2*W-1:W]};
                    for (int n = 0; n < W; n++) begin
                        crc_rise_d[n] = crc16_step(crc_rise_q[n], s_data[W+n]);
                        crc_fall_d[n] = crc16_step(crc_fall_q[n], s_data[n]);
                    end
                    beat_d = beat_q + BW'(1);
                    if (beat_q == BW'(NB - 1)) begin
                        state_d = S_CRC;
                        crc_i_d = 4'd0;
                    end
                end else begin
                    clk_en_d = 1'b0;
                end
            end
            S_CRC: begin
                // Registers shift out MSB first; they are cleared again in PRE.
                for (int n = 0; n < W; n++) begin
                    ddr_d_d[n]    = crc_rise_q[n][15];
                    ddr_d_d[W+n]  = crc_fall_q[n][15];
                    crc_rise_d[n] = {crc_rise_q[n][14:0], 1'b0};
                    crc_fall_d[n] = {crc_fall_q[n][14:0], 1'b0};
                end
                crc_i_d = crc_i_q + 4'd1;
                if (crc_i_q == 4'd15) state_d = S_END;
            end
            S_END: begin
                ddr_d_d      = '1;
                wait_entry_d = 1'b1;
                state_d      = S_WAIT;
            end
            S_WAIT: begin
                cnt_d = rem_blks;
                if (wait_entry_q) begin
                    ddr_oe_d   = 1'b0;
                    ddr_d_d    = '1;
                    blk_done_d = 1'b1;
                end
                if (blk_ack) begin
                    if (rem_blks != 16'd0) begin
                        state_d = S_PRE;
                    end else begin
                        state_d = S_IDLE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (abort) begin
            state_d      = S_IDLE;
            ddr_oe_d     = 1'b0;
            ddr_d_d      = '1;
            clk_en_d     = 1'b1;
            busy_d       = 1'b0;
            blk_done_d   = 1'b0;
            done_d       = 1'b0;
            wait_entry_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            beat_q       <= '0;
            crc_i_q      <= '0;
            wait_entry_q <= 1'b0;
            crc_rise_q   <= '0;
            crc_fall_q   <= '0;
            ddr_d_q      <= '1;
            ddr_oe_q     <= 1'b0;
            clk_en_q     <= 1'b1;
            busy_q       <= 1'b0;
            blk_done_q   <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            beat_q       <= beat_d;
            crc_i_q      <= crc_i_d;
            wait_entry_q <= wait_entry_d;
            crc_rise_q   <= crc_rise_d;
            crc_fall_q   <= crc_fall_d;
            ddr_d_q      <= ddr_d_d;
            ddr_oe_q     <= ddr_oe_d;
            clk_en_q     <= clk_en_d;
            busy_q       <= busy_d;
            blk_done_q   <= blk_done_d;
            done_q       <= done_d;
        end
    end

    assign ddr_d      = ddr_d_q;
    assign ddr_oe     = ddr_oe_q;
    assign ddr_clk_en = clk_en_q;
    assign busy       = busy_q;
    assign blk_done   = blk_done_q;
    assign done       = done_q;

endmodule
